// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tuse/Tnew hazard unit for the D stage. A shift-register scoreboard follows
// the destination register and remaining Tnew of every in-flight instruction
// from E onwards. From it the unit derives the D-stage stall and the forward
// selects for the D and E operand muxes. It also owns the mul/div busy counter.
//
// Optional feature macro: HAZ_STALL_CNT_EN
//   When defined, two free-running 32-bit statistics counters are added:
//   stall_cnt (cycles with stall=1) and md_stall_cnt (cycles stalled on the
//   mul/div unit). When undefined, those ports do not exist.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   d_valid      D holds a real instruction
//   d_rs, d_rt   D source registers
//   d_tuse_rs/rt cycles until D needs each source (all ones = unused)
//   d_dst        D destination register (0 = none)
//   d_tnew       cycles after entering E until the result is forwardable
//   d_md         D uses the mul/div unit
//   md_start     a mul/div operation starts in E this cycle
//   flush        kill every tracked instruction
//   stall        freeze PC and D, insert a bubble into E
//   md_busy      mul/div counter non-zero
//   d_fwd_rs/rt  D operand source: 0 = register file, k+1 = stage k
//   e_fwd_rs/rt  E operand source: 0 = no forward, k+1 = stage k (k >= 1)
//   stall_cnt, md_stall_cnt (HAZ_STALL_CNT_EN only) stall statistics
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NSTAGE = 3,
    parameter int TW     = 2,
    parameter int MD_LAT = 5,
    parameter int SELW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_valid,
    input  logic [4:0]      d_rs,
    input  logic [4:0]      d_rt,
    input  logic [TW-1:0]   d_tuse_rs,
    input  logic [TW-1:0]   d_tuse_rt,
    input  logic [4:0]      d_dst,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_md,
    input  logic            md_start,
    input  logic            flush,
    output logic            stall,
    output logic            md_busy,
    output logic [SELW-1:0] d_fwd_rs,
    output logic [SELW-1:0] d_fwd_rt,
    output logic [SELW-1:0] e_fwd_rs,
    output logic [SELW-1:0] e_fwd_rt
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     md_stall_cnt
`endif
);

    localparam int CW = $clog2(MD_LAT + 1);

    typedef struct packed {
        logic            hit;
        logic [TW-1:0]   tnew;
        logic [SELW-1:0] sel;
    } matchInfoT;

    logic [4:0]    entryDst  [NSTAGE];
    logic [TW-1:0] entryTnew [NSTAGE];
    logic [4:0]    eRs;
    logic [4:0]    eRt;
    logic [CW-1:0] mdCnt;

    matchInfoT dRsMatch, dRtMatch, eRsMatch, eRtMatch;
    logic      stallData;
    logic      stallMd;

    // Youngest scoreboard entry at or after firstStage that writes src.
    // Scanning from the oldest entry lets a younger hit overwrite an older one.
    function automatic matchInfoT youngestMatch(input logic [4:0] src,
                                                input int firstStage);
        matchInfoT m;
        m = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (k >= firstStage && src != 5'd0 && entryDst[k] == src) begin
                m.hit  = 1'b1;
                m.tnew = entryTnew[k];
                m.sel  = SELW'(k + 1);
            end
        end
        return m;
    endfunction

    // D compares against every tracked stage; E skips stage 0 because that
    // entry is the E instruction itself.
    always_comb begin
        dRsMatch = youngestMatch(d_rs, 0);
        dRtMatch = youngestMatch(d_rt, 0);
        eRsMatch = youngestMatch(eRs, 1);
        eRtMatch = youngestMatch(eRt, 1);
    end

    // A producer whose result is still further away than the consumer's need
    // forces a stall. When the result is ready now, D forwards it directly;
    // a producer that is close but not yet ready is picked up later in E.
    always_comb begin
        stallData = (dRsMatch.hit && (dRsMatch.tnew > d_tuse_rs)) ||
                    (dRtMatch.hit && (dRtMatch.tnew > d_tuse_rt));
        d_fwd_rs  = (dRsMatch.hit && dRsMatch.tnew == '0) ? dRsMatch.sel : '0;
        d_fwd_rt  = (dRtMatch.hit && dRtMatch.tnew == '0) ? dRtMatch.sel : '0;
        e_fwd_rs  = (eRsMatch.hit && eRsMatch.tnew == '0) ? eRsMatch.sel : '0;
        e_fwd_rt  = (eRtMatch.hit && eRtMatch.tnew == '0) ? eRtMatch.sel : '0;
        md_busy   = (mdCnt != '0);
        // md_start counts as busy so a mul/div instruction right behind the
        // starting one cannot slip through in the same cycle.
        stallMd   = d_valid && d_md && (md_busy || md_start);
        stall     = d_valid && (stallData || stallMd);
    end

    // Scoreboard shift. Entry 0 receives the instruction leaving D, or a
    // bubble while stalling; older entries age by one cycle as they move.
    // A flush empties the whole pipeline view at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                entryDst[k]  <= '0;
                entryTnew[k] <= '0;
            end
            eRs <= '0;
            eRt <= '0;
        end else if (flush) begin
            for (int k = 0; k < NSTAGE; k++) begin
                entryDst[k]  <= '0;
                entryTnew[k] <= '0;
            end
            eRs <= '0;
            eRt <= '0;
        end else begin
            entryDst[0]  <= stall ? 5'd0 : (d_valid ? d_dst : 5'd0);
            entryTnew[0] <= stall ? '0 : d_tnew;
            for (int k = 1; k < NSTAGE; k++) begin
                entryDst[k]  <= entryDst[k-1];
                entryTnew[k] <= (entryTnew[k-1] != '0) ? entryTnew[k-1] - TW'(1) : '0;
            end
            eRs <= stall ? 5'd0 : d_rs;
            eRt <= stall ? 5'd0 : d_rt;
        end
    end

    // Mul/div busy counter. It is deliberately unaffected by flush: an
    // operation already started keeps the unit occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdCnt <= '0;
        end else if (md_start) begin
            mdCnt <= CW'(MD_LAT);
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - CW'(1);
        end
    end

`ifdef HAZ_STALL_CNT_EN
    // Stall statistics, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (stallMd) begin
                md_stall_cnt <= md_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
